// File: rtl/fsm_trans_cov_if.sv
// ---------------------------------------------------------------------------
// fsm_trans_cov_if
//   Request/acknowledge readout port of the FSM transition-coverage monitor.
//   The requester asks whether transition rd_prev->rd_curr has been seen on
//   channel rd_ch; the monitor answers one cycle later with rd_ack/rd_hit.
//
//   rd_req   requester -> monitor   readout request (one query per cycle)
//   rd_ch    requester -> monitor   channel to query
//   rd_prev  requester -> monitor   queried previous state
//   rd_curr  requester -> monitor   queried current state
//   rd_ack   monitor -> requester   one-cycle acknowledge
//   rd_hit   monitor -> requester   bitmap bit, valid while rd_ack=1
//
//   master : the requester (mailbox, LED driver, testbench)
//   slave  : the monitor
// ---------------------------------------------------------------------------
interface fsm_trans_cov_if #(
  parameter int STATE_W = 4,
  parameter int CH      = 2
);
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic               rd_req;
  logic [CH_W-1:0]    rd_ch;
  logic [STATE_W-1:0] rd_prev;
  logic [STATE_W-1:0] rd_curr;
  logic               rd_ack;
  logic               rd_hit;

  modport master (
    output rd_req, rd_ch, rd_prev, rd_curr,
    input  rd_ack, rd_hit
  );

  modport slave (
    input  rd_req, rd_ch, rd_prev, rd_curr,
    output rd_ack, rd_hit
  );
endinterface

// File: rtl/fsm_trans_cov.sv
// ---------------------------------------------------------------------------
// fsm_trans_cov
//   On-chip FSM transition-coverage monitor. Samples the state registers of
//   CH independent FSMs, records every unique prev->curr transition in a
//   per-channel NS x NS bitmap and keeps a saturating unique-transition
//   counter per channel. Coverage is read back through a req/ack port.
//
//   Optional feature macro: FSM_TRANS_COV_LAST_EN
//     When defined, adds last_prev/last_curr/last_stamp outputs capturing the
//     most recent discovery per channel, stamped with a free-running 32-bit
//     cycle counter.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         global sample enable (0: nothing sampled, recorded, remembered)
//   state_in   packed channel states, channel c at [c*STATE_W +: STATE_W]
//   clr        synchronous clear of bitmaps, counters and prev-valid flags
//   new_tr     per-channel one-cycle pulse on a never-seen transition
//   uniq_cnt   packed per-channel unique-transition counts
//   rd         readout port (fsm_trans_cov_if.slave)
//   last_prev / last_curr / last_stamp   (FSM_TRANS_COV_LAST_EN only)
// ---------------------------------------------------------------------------
module fsm_trans_cov #(
  parameter int STATE_W     = 4,
  parameter int CH          = 2,
  parameter int CNT_W       = 2*STATE_W + 1,
  parameter int IGNORE_SELF = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [CH*STATE_W-1:0]  state_in,
  input  logic                   clr,
  output logic [CH-1:0]          new_tr,
  output logic [CH*CNT_W-1:0]    uniq_cnt,
`ifdef FSM_TRANS_COV_LAST_EN
  output logic [CH*STATE_W-1:0]  last_prev,
  output logic [CH*STATE_W-1:0]  last_curr,
  output logic [CH*32-1:0]       last_stamp,
`endif
  fsm_trans_cov_if.slave         rd
);

  localparam int NS   = 2**STATE_W;
  localparam int NT   = NS*NS;
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  // Bitmap bit index is {prev, curr}.
  logic [NT-1:0]      r_bitmap     [CH];
  logic [STATE_W-1:0] r_prev_state [CH];
  logic [CNT_W-1:0]   r_cnt        [CH];
  logic [CH-1:0]      r_prev_valid;
  logic [CH-1:0]      r_new_tr;
  logic               r_rd_ack;
  logic               r_rd_hit;

  logic [STATE_W-1:0]   w_state [CH];
  logic [2*STATE_W-1:0] w_idx   [CH];
  logic [CH-1:0]        w_rec;
  logic                 w_rd_bit;

  // A record happens only when a valid previous sample exists, the pair is
  // not a filtered self-loop, and the bitmap bit is still clear.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w_state[c] = state_in[c*STATE_W +: STATE_W];
      w_idx[c]   = {r_prev_state[c], w_state[c]};
      w_rec[c]   = en && r_prev_valid[c] && !r_bitmap[c][w_idx[c]] &&
                   !((IGNORE_SELF != 0) && (r_prev_state[c] == w_state[c]));
    end
  end

  // Channel select for readout; a channel number with no matching channel
  // leaves the bit at 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the loop leaves it unassigned, which would infer a latch.
    w_rd_bit = 1'b0;
    for (int c = 0; c < CH; c++) begin
      if (rd.rd_ch == CH_W'(c))
        w_rd_bit = r_bitmap[c][{rd.rd_prev, rd.rd_curr}];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the bitmap is plain flops, not RAM, so it is reset like any
      // other register; a half-cleared map after reset would be meaningless.
      for (int c = 0; c < CH; c++) begin
        r_bitmap[c]     <= '0;
        r_prev_state[c] <= '0;
        r_cnt[c]        <= '0;
      end
      r_prev_valid <= '0;
      r_new_tr     <= '0;
    end else if (clr) begin
      // Clear wins over any record on the same edge; state_in is ignored.
      for (int c = 0; c < CH; c++) begin
        r_bitmap[c] <= '0;
        r_cnt[c]    <= '0;
      end
      r_prev_valid <= '0;
      r_new_tr     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every channel reading the
      // pre-edge bitmap/prev state, independent of statement order.
      r_new_tr <= w_rec;
      for (int c = 0; c < CH; c++) begin
        if (en) begin
          r_prev_valid[c] <= 1'b1;
          r_prev_state[c] <= w_state[c];
        end
        if (w_rec[c]) begin
          r_bitmap[c][w_idx[c]] <= 1'b1;
          if (r_cnt[c] != '1)
            r_cnt[c] <= r_cnt[c] + CNT_W'(1);
        end
      end
    end
  end

  // Readout samples the bitmap before this edge's update (read-old), and is
  // independent of clr so a concurrent request returns the pre-clear value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ack <= 1'b0;
      r_rd_hit <= 1'b0;
    end else begin
      r_rd_ack <= rd.rd_req;
      r_rd_hit <= rd.rd_req & w_rd_bit;
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++)
      uniq_cnt[c*CNT_W +: CNT_W] = r_cnt[c];
  end

  assign new_tr    = r_new_tr;
  assign rd.rd_ack = r_rd_ack;
  assign rd.rd_hit = r_rd_hit;

`ifdef FSM_TRANS_COV_LAST_EN
  logic [31:0]        r_cycle;
  logic [STATE_W-1:0] r_last_prev  [CH];
  logic [STATE_W-1:0] r_last_curr  [CH];
  logic [31:0]        r_last_stamp [CH];

  // Free-running; only reset clears it, clr does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cycle <= '0;
    else        r_cycle <= r_cycle + 32'd1;
  end

  // Stamp is the counter value seen at the sampling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        r_last_prev[c]  <= '0;
        r_last_curr[c]  <= '0;
        r_last_stamp[c] <= '0;
      end
    end else if (clr) begin
      for (int c = 0; c < CH; c++) begin
        r_last_prev[c]  <= '0;
        r_last_curr[c]  <= '0;
        r_last_stamp[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (w_rec[c]) begin
          r_last_prev[c]  <= r_prev_state[c];
          r_last_curr[c]  <= w_state[c];
          r_last_stamp[c] <= r_cycle;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      last_prev[c*STATE_W +: STATE_W] = r_last_prev[c];
      last_curr[c*STATE_W +: STATE_W] = r_last_curr[c];
      last_stamp[c*32 +: 32]          = r_last_stamp[c];
    end
  end
`endif

endmodule

// File: tb/tb_fsm_trans_cov.sv
module tb_fsm_trans_cov;
  localparam int STATE_W     = 4;
  localparam int CH          = 2;
  localparam int CNT_W       = 2*STATE_W + 1;
  localparam int IGNORE_SELF = 0;
  localparam int NS          = 2**STATE_W;
  localparam int CNT_MAX     = 2**CNT_W - 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en = 1'b0;
  logic [CH*STATE_W-1:0] state_in = '0;
  logic                  clr = 1'b0;
  logic [CH-1:0]         new_tr;
  logic [CH*CNT_W-1:0]   uniq_cnt;
`ifdef FSM_TRANS_COV_LAST_EN
  logic [CH*STATE_W-1:0] last_prev;
  logic [CH*STATE_W-1:0] last_curr;
  logic [CH*32-1:0]      last_stamp;
  int unsigned           tb_cyc;
`endif

  fsm_trans_cov_if #(.STATE_W(STATE_W), .CH(CH)) rd_if ();

  fsm_trans_cov #(
    .STATE_W(STATE_W), .CH(CH), .CNT_W(CNT_W), .IGNORE_SELF(IGNORE_SELF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .state_in(state_in), .clr(clr),
    .new_tr(new_tr), .uniq_cnt(uniq_cnt),
`ifdef FSM_TRANS_COV_LAST_EN
    .last_prev(last_prev), .last_curr(last_curr), .last_stamp(last_stamp),
`endif
    .rd(rd_if)
  );

  always #5 clk = ~clk;

`ifdef FSM_TRANS_COV_LAST_EN
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: set of seen transitions, last enabled sample, counts.
  bit          m_seen [CH][NS][NS];
  bit          m_pv   [CH];
  int          m_ps   [CH];
  int          m_cnt  [CH];
  bit [CH-1:0] m_new;
  bit          m_ack;
  bit          m_hit;

  function automatic logic [CH*CNT_W-1:0] exp_cnt();
    logic [CH*CNT_W-1:0] r;
    for (int c = 0; c < CH; c++) r[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
    return r;
  endfunction

  function automatic int cnt_of(int c);
    logic [CNT_W-1:0] v;
    v = uniq_cnt[c*CNT_W +: CNT_W];
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_pv[c] = 0; m_ps[c] = 0; m_cnt[c] = 0;
      for (int p = 0; p < NS; p++)
        for (int s = 0; s < NS; s++) m_seen[c][p][s] = 0;
    end
    m_new = '0; m_ack = 0; m_hit = 0;
  endtask

  task automatic set_state(int c, int s);
    state_in[c*STATE_W +: STATE_W] = STATE_W'(s);
  endtask

  task automatic set_rd(bit req, int c, int p, int s);
    rd_if.rd_req  = req;
    rd_if.rd_ch   = 1'(c);
    rd_if.rd_prev = STATE_W'(p);
    rd_if.rd_curr = STATE_W'(s);
  endtask

  // One clock edge: the model applies the rules to the inputs present at the
  // edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    int s;
    @(posedge clk);
    m_ack = rd_if.rd_req;
    m_hit = 0;
    if (rd_if.rd_req && int'(rd_if.rd_ch) < CH)
      m_hit = m_seen[int'(rd_if.rd_ch)][int'(rd_if.rd_prev)][int'(rd_if.rd_curr)];
    if (clr) begin
      for (int c = 0; c < CH; c++) begin
        m_pv[c] = 0; m_cnt[c] = 0;
        for (int p = 0; p < NS; p++)
          for (int q = 0; q < NS; q++) m_seen[c][p][q] = 0;
      end
      m_new = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_new[c] = 0;
        if (en) begin
          s = int'(state_in[c*STATE_W +: STATE_W]);
          if (m_pv[c] && !(IGNORE_SELF != 0 && m_ps[c] == s) && !m_seen[c][m_ps[c]][s]) begin
            m_seen[c][m_ps[c]][s] = 1;
            m_new[c] = 1;
            if (m_cnt[c] < CNT_MAX) m_cnt[c]++;
          end
          m_pv[c] = 1;
          m_ps[c] = s;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 0; clr = 0; state_in = '0; set_rd(0, 0, 0, 0);
    model_reset();
    #12;
    n_checks++;
    if (new_tr !== '0 || uniq_cnt !== '0 || rd_if.rd_ack !== 1'b0 || rd_if.rd_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: new_tr=%b uniq_cnt=%h ack=%b hit=%b, required all 0",
               new_tr, uniq_cnt, rd_if.rd_ack, rd_if.rd_hit);
    end
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  task automatic test_sequence();
    int  seq[6]   = '{0, 1, 2, 1, 2, 7};
    bit  pulse[6] = '{0, 1, 1, 1, 0, 1};
    en = 1; set_state(1, 3);
    for (int i = 0; i < 6; i++) begin
      set_state(0, seq[i]);
      tick();
      n_checks++;
      if (new_tr[0] !== pulse[i] || new_tr !== m_new) begin
        n_fail++;
        $display("FAIL seq_new_tr[%0d]: got %b, required %b (ch0 %b)", i, new_tr, m_new, pulse[i]);
      end
    end
    n_checks++;
    if (cnt_of(0) != 4 || uniq_cnt !== exp_cnt()) begin
      n_fail++;
      $display("FAIL seq_uniq_cnt: got %h, required %h (ch0=4)", uniq_cnt, exp_cnt());
    end
  endtask

  task automatic test_self_hold();
    clr = 1; tick(); clr = 0;
    set_state(0, 5);
    set_state(1, 3);
    for (int i = 0; i < 5; i++) tick();
    set_state(1, 5); tick();
    n_checks++;
    if (cnt_of(1) != (IGNORE_SELF ? 1 : 2) || uniq_cnt !== exp_cnt()) begin
      n_fail++;
      $display("FAIL self_hold_cnt: got ch1=%0d, required %0d", cnt_of(1), IGNORE_SELF ? 1 : 2);
    end
  endtask

  task automatic test_enable_gap();
    clr = 1; tick(); clr = 0;
    set_state(1, 2);
    set_state(0, 0); tick();
    set_state(0, 4); tick();
    en = 0; set_state(0, 9);
    for (int i = 0; i < 3; i++) tick();
    en = 1; set_state(0, 6); tick();
    n_checks++;
    if (new_tr[0] !== 1'b1 || uniq_cnt !== exp_cnt()) begin
      n_fail++;
      $display("FAIL gap_record: new_tr=%b cnt=%h, required new_tr[0]=1 cnt=%h", new_tr, uniq_cnt, exp_cnt());
    end
    set_rd(1, 0, 4, 6); tick();
    n_checks++;
    if (rd_if.rd_ack !== 1'b1 || rd_if.rd_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_read_4_6: ack=%b hit=%b, required 1 1", rd_if.rd_ack, rd_if.rd_hit);
    end
    set_rd(1, 0, 4, 9); tick();
    n_checks++;
    if (rd_if.rd_ack !== 1'b1 || rd_if.rd_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_read_4_9: ack=%b hit=%b, required 1 0", rd_if.rd_ack, rd_if.rd_hit);
    end
    set_rd(0, 0, 0, 0);
  endtask

  task automatic test_clr_concurrent();
    // ch0 prev is 6; 6->11 is new but clr wins. A read of 4->6 sees pre-clear.
    set_state(0, 11); clr = 1; set_rd(1, 0, 4, 6);
    tick();
    clr = 0; set_rd(0, 0, 0, 0);
    n_checks++;
    if (new_tr !== '0 || uniq_cnt !== '0) begin
      n_fail++;
      $display("FAIL clr_wins: new_tr=%b cnt=%h, required 0 0", new_tr, uniq_cnt);
    end
    n_checks++;
    if (rd_if.rd_ack !== 1'b1 || rd_if.rd_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_read_old: ack=%b hit=%b, required 1 1", rd_if.rd_ack, rd_if.rd_hit);
    end
    set_state(0, 12); tick();
    n_checks++;
    if (new_tr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_first_sample: new_tr[0]=%b, required 0", new_tr[0]);
    end
    set_state(0, 13); tick();
    n_checks++;
    if (new_tr[0] !== 1'b1 || cnt_of(0) != 1 || uniq_cnt !== exp_cnt()) begin
      n_fail++;
      $display("FAIL clr_second_sample: new_tr=%b cnt0=%0d, required new_tr[0]=1 cnt0=1", new_tr, cnt_of(0));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      en = 1'($urandom_range(0, 1));
      set_state(0, $urandom_range(10, 14));
      set_state(1, $urandom_range(0, 3));
      set_rd(1, $urandom_range(0, CH-1), $urandom_range(0, 15), $urandom_range(0, 15));
      if (i % 3 == 0) set_rd(1, 0, 12, 13);
      tick();
      n_checks++;
      if (rd_if.rd_ack !== 1'b1 || rd_if.rd_hit !== m_hit || new_tr !== m_new) begin
        n_fail++;
        $display("FAIL b2b_read[%0d]: ack=%b hit=%b new=%b, required 1 %b %b",
                 i, rd_if.rd_ack, rd_if.rd_hit, new_tr, m_hit, m_new);
      end
    end
    set_rd(0, 0, 0, 0); tick();
    n_checks++;
    if (rd_if.rd_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ack_drop: ack=%b, required 0", rd_if.rd_ack);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < CH; c++) set_state(c, $urandom_range(0, 5));
      set_rd($urandom_range(0, 1), $urandom_range(0, CH-1), $urandom_range(0, 5), $urandom_range(0, 5));
      tick();
      n_checks++;
      if (new_tr !== m_new || uniq_cnt !== exp_cnt() || rd_if.rd_ack !== m_ack ||
          (m_ack && rd_if.rd_hit !== m_hit)) begin
        n_fail++;
        $display("FAIL random[%0d]: new=%b cnt=%h ack=%b hit=%b, required %b %h %b %b",
                 i, new_tr, uniq_cnt, rd_if.rd_ack, rd_if.rd_hit, m_new, exp_cnt(), m_ack, m_hit);
      end
    end
    clr = 0;
  endtask

  task automatic test_async_reset();
    int set_bits[$];
    en = 1;
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < CH; c++) set_state(c, $urandom_range(0, 7));
      set_rd(1, 0, 0, 0);
      tick();
    end
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < NS; p++)
        for (int s = 0; s < NS; s++)
          if (m_seen[c][p][s] && set_bits.size() < 12) set_bits.push_back(c*NS*NS + p*NS + s);
    n_checks++;
    if (uniq_cnt === '0 || rd_if.rd_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_active: cnt=%h ack=%b, required nonzero 1", uniq_cnt, rd_if.rd_ack);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (new_tr !== '0 || uniq_cnt !== '0 || rd_if.rd_ack !== 1'b0 || rd_if.rd_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: new=%b cnt=%h ack=%b hit=%b, required all 0",
               new_tr, uniq_cnt, rd_if.rd_ack, rd_if.rd_hit);
    end
`ifdef FSM_TRANS_COV_LAST_EN
    n_checks++;
    if (last_prev !== '0 || last_curr !== '0 || last_stamp !== '0) begin
      n_fail++;
      $display("FAIL async_reset_last: prev=%h curr=%h stamp=%h, required 0", last_prev, last_curr, last_stamp);
    end
`endif
    en = 0;
    @(negedge clk); rst_n = 1'b1; #1;
    foreach (set_bits[k]) begin
      set_rd(1, set_bits[k] / (NS*NS), (set_bits[k] / NS) % NS, set_bits[k] % NS);
      tick();
      n_checks++;
      if (rd_if.rd_ack !== 1'b1 || rd_if.rd_hit !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_read[%0d]: ack=%b hit=%b, required 1 0", k, rd_if.rd_ack, rd_if.rd_hit);
      end
    end
    set_rd(0, 0, 0, 0);
  endtask

`ifdef FSM_TRANS_COV_LAST_EN
  task automatic test_last();
    int guard = 0;
    rst_n = 1'b0; #1; model_reset();
    @(negedge clk); rst_n = 1'b1; #1;
    en = 1; clr = 0; set_state(1, 0);
    set_state(0, 7); tick();
    set_state(0, 2);
    while (tb_cyc < 40 && guard < 100) begin tick(); guard++; end
    set_state(0, 7); tick();
    n_checks++;
    if (last_prev[3:0] !== 4'd2 || last_curr[3:0] !== 4'd7 || last_stamp[31:0] !== 32'd40) begin
      n_fail++;
      $display("FAIL last_capture: prev=%0d curr=%0d stamp=%0d, required 2 7 40",
               last_prev[3:0], last_curr[3:0], last_stamp[31:0]);
    end
    set_state(0, 2); tick();
    set_state(0, 7); tick();
    n_checks++;
    if (last_prev[3:0] !== 4'd2 || last_curr[3:0] !== 4'd7 || last_stamp[31:0] !== 32'd40 || new_tr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL last_repeat: prev=%0d curr=%0d stamp=%0d new=%b, required 2 7 40 0",
               last_prev[3:0], last_curr[3:0], last_stamp[31:0], new_tr[0]);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequence();
    test_self_hold();
    test_enable_gap();
    test_clr_concurrent();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef FSM_TRANS_COV_LAST_EN
    test_last();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
